// File: rtl/nvdla_glb_pkg.sv
// ----------------------------------------------------------------------------
// nvdla_glb_pkg
// Shared definitions for the GLB interrupt collector:
//   - GLB_INTR_W        : width of the done status / mask / pulse vectors
//   - GLB_BIT_*         : bit position of each engine's done source
//   - GLB_INTR_RSVD_MASK: bits [15:10], which never hold status
//   - glb_intr_state_e  : states of the interrupt gap FSM
// ----------------------------------------------------------------------------
package nvdla_glb_pkg;

    localparam int GLB_INTR_W = 22;

    localparam int GLB_BIT_SDP0      = 0;
    localparam int GLB_BIT_SDP1      = 1;
    localparam int GLB_BIT_CDP0      = 2;
    localparam int GLB_BIT_CDP1      = 3;
    localparam int GLB_BIT_PDP0      = 4;
    localparam int GLB_BIT_PDP1      = 5;
    localparam int GLB_BIT_BDMA0     = 6;
    localparam int GLB_BIT_BDMA1     = 7;
    localparam int GLB_BIT_RUBIK0    = 8;
    localparam int GLB_BIT_RUBIK1    = 9;
    localparam int GLB_BIT_CDMA_DAT0 = 16;
    localparam int GLB_BIT_CDMA_DAT1 = 17;
    localparam int GLB_BIT_CDMA_WT0  = 18;
    localparam int GLB_BIT_CDMA_WT1  = 19;
    localparam int GLB_BIT_CACC0     = 20;
    localparam int GLB_BIT_CACC1     = 21;

    localparam logic [GLB_INTR_W-1:0] GLB_INTR_RSVD_MASK = 22'h00FC00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } glb_intr_state_e;

endpackage

// File: rtl/nvdla_glb_intr_gap_fsm.sv
// ----------------------------------------------------------------------------
// nvdla_glb_intr_gap_fsm
// Turns the level "pending" indication into a registered interrupt that is
// forced low for at least INTR_GAP cycles after every deassertion, so an
// edge-sensitive host sees a fresh edge for each new event.
// Ports:
//   i_clk       : core clock
//   i_rst_n     : asynchronous active-low reset
//   i_pending   : 1 when any unmasked status bit is set
//   o_core_intr : registered interrupt, polarity set by INTR_POLARITY
// ----------------------------------------------------------------------------
module nvdla_glb_intr_gap_fsm
    import nvdla_glb_pkg::*;
#(
    parameter int INTR_GAP      = 4,   // 1..15
    parameter int INTR_POLARITY = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pending,
    output logic o_core_intr
);

    localparam logic       ACTIVE_LVL   = (INTR_POLARITY != 0);
    localparam logic       INACTIVE_LVL = ~ACTIVE_LVL;
    // The cycle spent transitioning ASSERT->GAP counts as the first low cycle,
    // so the counter starts one short of the full gap.
    localparam logic [3:0] GAP_LOAD     = 4'(INTR_GAP - 1);

    glb_intr_state_e r_state;
    glb_intr_state_e w_state_next;
    logic [3:0]      r_gap_cnt;
    logic [3:0]      w_gap_cnt_next;
    logic            r_core_intr;
    logic            w_core_intr_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_gap_cnt   <= 4'd0;
            r_core_intr <= INACTIVE_LVL;
        end else begin
            r_state     <= w_state_next;
            r_gap_cnt   <= w_gap_cnt_next;
            r_core_intr <= w_core_intr_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_gap_cnt_next = r_gap_cnt;
        case (r_state)
            IDLE: begin
                if (i_pending) begin
                    w_state_next = ASSERT;
                end
            end
            ASSERT: begin
                if (!i_pending) begin
                    w_state_next   = GAP;
                    w_gap_cnt_next = GAP_LOAD;
                end
            end
            GAP: begin
                // Pending is ignored until the gap has fully elapsed.
                if (r_gap_cnt == 4'd0) begin
                    w_state_next = i_pending ? ASSERT : IDLE;
                end else begin
                    w_gap_cnt_next = r_gap_cnt - 4'd1;
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_gap_cnt_next = 4'd0;
            end
        endcase
        // Output is registered off the next state so it changes on the same
        // edge as the state transition.
        w_core_intr_next = (w_state_next == ASSERT) ? ACTIVE_LVL : INACTIVE_LVL;
    end

    assign o_core_intr = r_core_intr;

endmodule

// File: rtl/nvdla_glb_intr_ctrl.sv
// ----------------------------------------------------------------------------
// nvdla_glb_intr_ctrl
// GLB interrupt collector: latches engine done pulses into sticky status
// bits, supports software set and write-1-to-clear, applies the done masks
// and drives the registered core interrupt through the gap FSM.
// Ports:
//   nvdla_core_clk    : core clock
//   nvdla_core_rstn   : asynchronous active-low reset
//   eng_done_pulse    : 1-cycle engine done pulses (GLB bit layout)
//   done_mask         : 1 = source masked from the interrupt
//   req_wdat          : CSB write data, valid with the triggers
//   status_wr_trigger : W1C of done_status using req_wdat[21:0]
//   set_wr_trigger    : set of done_status using req_wdat[21:0]
//   done_status       : raw sticky status (unmasked)
//   core_intr         : registered interrupt to the SoC
// ----------------------------------------------------------------------------
module nvdla_glb_intr_ctrl
    import nvdla_glb_pkg::*;
#(
    parameter int INTR_GAP      = 4,
    parameter int INTR_POLARITY = 1
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    input  logic [GLB_INTR_W-1:0] eng_done_pulse,
    input  logic [GLB_INTR_W-1:0] done_mask,
    input  logic [31:0]           req_wdat,
    input  logic                  status_wr_trigger,
    input  logic                  set_wr_trigger,
    output logic [GLB_INTR_W-1:0] done_status,
    output logic                  core_intr
);

    logic [GLB_INTR_W-1:0] r_done_status;
    logic [GLB_INTR_W-1:0] w_clr;
    logic [GLB_INTR_W-1:0] w_set;
    logic [GLB_INTR_W-1:0] w_status_next;
    logic                  w_pending;
    logic                  w_unused_wdat;

    // Upper write-data bits carry no status.
    assign w_unused_wdat = ^req_wdat[31:GLB_INTR_W];

    assign w_clr = status_wr_trigger ? req_wdat[GLB_INTR_W-1:0] : '0;
    assign w_set = eng_done_pulse | (set_wr_trigger ? req_wdat[GLB_INTR_W-1:0] : '0);

    // Clear is applied first so a coincident set always wins; reserved bits
    // are forced to zero regardless of pulses or writes.
    assign w_status_next = ((r_done_status & ~w_clr) | w_set) & ~GLB_INTR_RSVD_MASK;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_done_status <= '0;
        end else begin
            r_done_status <= w_status_next;
        end
    end

    // Masks gate only the interrupt; the status read path stays raw.
    assign w_pending = |(r_done_status & ~done_mask);

    nvdla_glb_intr_gap_fsm #(
        .INTR_GAP      (INTR_GAP),
        .INTR_POLARITY (INTR_POLARITY)
    ) u_gap_fsm (
        .i_clk       (nvdla_core_clk),
        .i_rst_n     (nvdla_core_rstn),
        .i_pending   (w_pending),
        .o_core_intr (core_intr)
    );

    assign done_status = r_done_status;

endmodule
